kernel_stream_tap_buffer: RTL and testbench

Parametrised multi-tap stream offset buffer that aligns parallel dataflow paths with mismatched latencies inside TyBEC-generated kernel tops. A single input stream is shifted through a SIZE-deep register bank and presented at NTAPS compile-time delays, each tap with its own valid/ready handshake. It adds true back-pressure, an end-of-stream drain with per-tap last flags, and an occupancy count.

---
 rtl/kernel_stream_tap_buffer.sv | 126 ++++++++++++
 tb/tb_kernel_stream_tap_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/kernel_stream_tap_buffer.sv
// kernel_stream_tap_buffer: shift-register stream buffer presenting one input stream
// at NTAPS fixed delays, with per-tap handshakes, end-of-stream drain and occupancy.
`default_nettype none

module kernel_stream_tap_buffer #(
    parameter int unsigned           STREAMW = 34,
    parameter int unsigned           SIZE    = 24,
    parameter int unsigned           NTAPS   = 2,
    parameter logic [8*NTAPS-1:0]    TAPS    = {8'd24, 8'd1},
    parameter int unsigned           CNTW    = $clog2(SIZE + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     ivalid_i,
    input  logic                     ilast_i,
    input  logic [STREAMW-1:0]       in_i,
    output logic                     iready_o,
    output logic [NTAPS-1:0]         ovalid_o,
    input  logic [NTAPS-1:0]         oready_i,
    output logic [NTAPS-1:0]         olast_o,
    output logic [NTAPS*STREAMW-1:0] out_o,
    output logic [CNTW-1:0]          occupancy_o
);

    localparam logic [7:0]      DMAX   = TAPS[8*(NTAPS-1) +: 8];
    localparam logic [CNTW-1:0] SIZE_C = CNTW'(SIZE);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e             state_q;
    logic [STREAMW-1:0] bank_q [SIZE];
    logic [SIZE-1:0]    vb_q;
    logic [7:0]         dcnt_q;
    logic [CNTW-1:0]    occ_q;

    logic               shift;
    logic [NTAPS-1:0]   tap_vb;
    logic [NTAPS-1:0]   tap_prev_vb;

    generate
        for (genvar k = 0; k < NTAPS; k++) begin : g_tap
            localparam int unsigned D = int'(TAPS[8*k +: 8]);
            assign tap_vb[k] = vb_q[D-1];
            assign out_o[k*STREAMW +: STREAMW] = bank_q[D-1];
            // The slot behind a delay-1 tap is the input itself, which is empty while draining.
            if (D == 1) begin : g_first
                assign tap_prev_vb[k] = 1'b0;
            end else begin : g_later
                assign tap_prev_vb[k] = vb_q[D-2];
            end
        end
    endgenerate

    always_comb begin
        iready_o = 1'b0;
        ovalid_o = '0;
        olast_o  = '0;
        shift    = 1'b0;
        unique case (state_q)
            RUN: begin
                iready_o = &oready_i;
                ovalid_o = tap_vb & {NTAPS{ivalid_i}};
                shift    = ivalid_i & (&oready_i);
            end
            DRAIN: begin
                ovalid_o = tap_vb;
                olast_o  = tap_vb & ~tap_prev_vb;
                shift    = &(oready_i | ~tap_vb);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            vb_q    <= '0;
            dcnt_q  <= '0;
            occ_q   <= '0;
            for (int i = 0; i < int'(SIZE); i++) begin
                bank_q[i] <= '0;
            end
        end else if (shift) begin
            for (int i = int'(SIZE) - 1; i > 0; i--) begin
                bank_q[i] <= bank_q[i-1];
                vb_q[i]   <= vb_q[i-1];
            end
            unique case (state_q)
                RUN: begin
                    bank_q[0] <= in_i;
                    vb_q[0]   <= 1'b1;
                    if (occ_q < SIZE_C) begin
                        occ_q <= occ_q + 1'b1;
                    end
                    if (ilast_i) begin
                        state_q <= DRAIN;
                        dcnt_q  <= '0;
                    end
                end
                DRAIN: begin
                    bank_q[0] <= '0;
                    vb_q[0]   <= 1'b0;
                    if (dcnt_q == DMAX - 8'd1) begin
                        state_q <= RUN;
                        dcnt_q  <= '0;
                        occ_q   <= '0;
                    end else begin
                        dcnt_q <= dcnt_q + 8'd1;
                        if (occ_q != '0) begin
                            occ_q <= occ_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign occupancy_o = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_kernel_stream_tap_buffer.sv
// Scoreboard bench for kernel_stream_tap_buffer: every accepted word is expected once on
// every tap, in order, with olast on the final word of the stream during drain.
`default_nettype none

module tb_kernel_stream_tap_buffer;

    localparam int          STREAMW = 8;
    localparam int          SIZE    = 8;
    localparam int          NTAPS   = 2;
    localparam logic [15:0] TAPS    = {8'd4, 8'd1};
    localparam int          CNTW    = $clog2(SIZE + 1);
    localparam int          DMAX    = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     ivalid = 1'b0;
    logic                     ilast = 1'b0;
    logic [STREAMW-1:0]       din = '0;
    logic                     iready;
    logic [NTAPS-1:0]         ovalid;
    logic [NTAPS-1:0]         oready = 2'b11;
    logic [NTAPS-1:0]         olast;
    logic [NTAPS*STREAMW-1:0] dout;
    logic [CNTW-1:0]          occ_o;

    kernel_stream_tap_buffer #(
        .STREAMW(STREAMW), .SIZE(SIZE), .NTAPS(NTAPS), .TAPS(TAPS), .CNTW(CNTW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .ivalid_i(ivalid), .ilast_i(ilast), .in_i(din),
        .iready_o(iready), .ovalid_o(ovalid), .oready_i(oready), .olast_o(olast),
        .out_o(dout), .occupancy_o(occ_o)
    );

    always #5 clk = ~clk;

    int               nvec = 0;
    int               nerr = 0;
    int               tapd [NTAPS] = '{1, 4};
    logic [7:0]       words[$];
    int               hd   [NTAPS];
    bit               drain = 1'b0;
    int               dsh = 0;
    int               occ = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        words.delete();
        for (int k = 0; k < NTAPS; k++) hd[k] = 0;
        drain = 1'b0;
        dsh   = 0;
        occ   = 0;
    endtask

    // One clock: drive at the falling edge, check 1ns later, advance the model.
    task automatic cyc(input logic v, input logic l, input logic [7:0] d, input logic [1:0] r);
        logic [1:0] ev;
        logic       erdy;
        logic       sh;
        int         rem;
        @(negedge clk);
        ivalid = v; ilast = l; din = d; oready = r;
        #1;
        erdy = drain ? 1'b0 : (&r);
        for (int k = 0; k < NTAPS; k++) begin
            rem = words.size() - hd[k];
            if (drain) ev[k] = (rem > 0) && (dsh + rem == tapd[k]);
            else       ev[k] = v && (rem >= tapd[k]);
        end
        sh = drain ? (&(r | ~ev)) : (v & erdy);
        chk("iready", {31'd0, iready}, {31'd0, erdy});
        chk("occupancy", 32'(occ_o), 32'(occ));
        for (int k = 0; k < NTAPS; k++) begin
            chk($sformatf("ovalid[%0d]", k), {31'd0, ovalid[k]}, {31'd0, ev[k]});
            chk($sformatf("olast[%0d]", k), {31'd0, olast[k]},
                {31'd0, drain & ev[k] & (hd[k] == words.size() - 1)});
            if (ev[k]) begin
                chk($sformatf("out[%0d]", k), 32'(dout[k*STREAMW +: STREAMW]), 32'(words[hd[k]]));
            end
        end
        if (sh) begin
            for (int k = 0; k < NTAPS; k++) if (ev[k]) hd[k]++;
            if (!drain) begin
                if (occ < SIZE) occ++;
                words.push_back(d);
                if (l) begin
                    drain = 1'b1;
                    dsh   = 0;
                end
            end else begin
                dsh++;
                if (dsh == DMAX) begin
                    for (int k = 0; k < NTAPS; k++) begin
                        chk($sformatf("drained[%0d]", k), 32'(hd[k]), 32'(words.size()));
                    end
                    model_clear();
                end else if (occ > 0) begin
                    occ--;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 2'b11);
    endtask

    task automatic chk_reset_outputs();
        chk("rst ovalid", 32'(ovalid), 32'd0);
        chk("rst olast", 32'(olast), 32'd0);
        chk("rst out", 32'(dout), 32'd0);
        chk("rst occupancy", 32'(occ_o), 32'd0);
        chk("rst iready", {31'd0, iready}, {31'd0, &oready});
    endtask

    initial begin
        model_clear();
        // Power-up reset.
        #2;
        chk_reset_outputs();
        #20;
        rst_n = 1'b1;

        // Continuous stream 10..19.
        for (int i = 0; i < 10; i++) cyc(1'b1, i == 9, 8'(10 + i), 2'b11);
        idle(6);

        // Back-pressure from tap1 for three cycles, then a drain-time stall.
        for (int i = 0; i < 10; i++) begin
            if (i == 5) for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 8'(20 + i), 2'b01);
            cyc(1'b1, i == 9, 8'(20 + i), 2'b11);
        end
        cyc(1'b0, 1'b0, 8'h00, 2'b01);
        cyc(1'b0, 1'b0, 8'h00, 2'b01);
        idle(6);

        // Gapped input.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, i == 9, 8'(30 + i), 2'b11);
            if (i % 3 == 0 && i != 9) begin
                cyc(1'b0, 1'b0, 8'hAA, 2'b11);
                cyc(1'b0, 1'b1, 8'hBB, 2'b11);
            end
        end
        idle(6);

        // Short stream shorter than the longest delay.
        cyc(1'b1, 1'b0, 8'd10, 2'b11);
        cyc(1'b1, 1'b1, 8'd11, 2'b11);
        idle(6);

        // Reset in the middle of a drain with five words still held.
        for (int i = 0; i < 6; i++) cyc(1'b1, i == 5, 8'(60 + i), 2'b11);
        cyc(1'b0, 1'b0, 8'h00, 2'b11);
        cyc(1'b0, 1'b0, 8'h00, 2'b10);
        chk("pre-reset occupancy", 32'(occ_o), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        model_clear();
        #5;
        rst_n = 1'b1;

        // Occupancy saturation over a 12-word stream.
        for (int i = 0; i < 12; i++) cyc(1'b1, i == 11, 8'(40 + i), 2'b11);
        idle(6);
        chk("final idle occupancy", 32'(occ_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
